// File: rtl/seq_chunk_adder_pkg.sv
// Shared definitions for the chunked multi-cycle adder/subtractor.
package seq_chunk_adder_pkg;

    // Sequencer states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Legal configuration: chunk fits inside the word and divides it evenly.
    function automatic bit chunk_cfg_ok(input int unsigned width, input int unsigned chunk);
        return (chunk >= 1) && (chunk <= width) && ((width % chunk) == 0);
    endfunction

endpackage

// File: rtl/seq_chunk_adder_chunk.sv
// Combinational CHUNK-bit adder slice, reused once per cycle by the sequencer.
module chunk_adder #(
    parameter int unsigned CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co
);

    // Plain add of one slice with carry-in; top bit of the widened sum is carry-out.
    always_comb begin
        {co, s} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, ci};
    end

endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle WIDTH-bit adder/subtractor processing CHUNK bits per clock,
// LSB chunk first, with a registered inter-chunk carry and result flags.
module seq_chunk_adder
    import seq_chunk_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Zf,
    output logic             Sf,
    output logic             Pf,
    output logic             OVf
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    if (!chunk_cfg_ok(WIDTH, CHUNK)) begin : g_cfg_check
        $error("seq_chunk_adder: WIDTH must be a non-zero multiple of CHUNK");
    end

    state_t            state;
    state_t            state_next;
    logic              load;
    logic              step;
    logic              last;

    logic [WIDTH-1:0]  a_reg;
    logic [WIDTH-1:0]  b_reg;      // already inverted for subtract
    logic              carry;
    logic [IDXW-1:0]   idx;

    int unsigned       base;
    logic [CHUNK-1:0]  a_chunk;
    logic [CHUNK-1:0]  b_chunk;
    logic [CHUNK-1:0]  s_chunk;
    logic              c_chunk;
    logic [WIDTH-1:0]  sum_next;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and datapath controls; start is honoured only in IDLE/DONE.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        last       = (idx == IDXW'(NCHUNK - 1));
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                step = 1'b1;
                if (last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Select the current chunk of each operand.
    always_comb begin
        base    = 32'(idx) * CHUNK;
        a_chunk = a_reg[base +: CHUNK];
        b_chunk = b_reg[base +: CHUNK];
    end

    chunk_adder #(
        .CHUNK (CHUNK)
    ) u_chunk_adder (
        .a  (a_chunk),
        .b  (b_chunk),
        .ci (carry),
        .s  (s_chunk),
        .co (c_chunk)
    );

    // Sum with the current chunk merged in, so flags see the complete result on the last step.
    always_comb begin
        sum_next               = Sum;
        sum_next[base +: CHUNK] = s_chunk;
    end

    // Operand latch, chunk sequencing, result and flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg <= '0;
            b_reg <= '0;
            carry <= 1'b0;
            idx   <= '0;
            Sum   <= '0;
            Cout  <= 1'b0;
            Zf    <= 1'b0;
            Sf    <= 1'b0;
            Pf    <= 1'b0;
            OVf   <= 1'b0;
        end else if (load) begin
            a_reg <= A;
            b_reg <= sub ? ~B : B;
            carry <= sub ? 1'b1 : Cin;
            idx   <= '0;
            Sum   <= '0;
        end else if (step) begin
            Sum   <= sum_next;
            carry <= c_chunk;
            if (!last) begin
                idx <= idx + 1'b1;
            end else begin
                Cout <= c_chunk;
                Zf   <= (sum_next == '0);
                Sf   <= sum_next[WIDTH-1];
                Pf   <= ~^sum_next;
                OVf  <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                        (sum_next[WIDTH-1] != a_reg[WIDTH-1]);
            end
        end
    end

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Self-checking bench: three instances (CHUNK = 4, 1, 16) against an arithmetic reference model.
module tb_seq_chunk_adder;

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        zf;
        logic        sf;
        logic        pf;
        logic        ov;
    } res_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        sub;
    logic        Cin;
    logic [15:0] A;
    logic [15:0] B;
    logic        start4, start1, start16;

    logic        busy4, done4, cout4, zf4, sf4, pf4, ov4;
    logic        busy1, done1, cout1, zf1, sf1, pf1, ov1;
    logic        busy16, done16, cout16, zf16, sf16, pf16, ov16;
    logic [15:0] sum4, sum1, sum16;

    int          sel;
    logic        o_busy, o_done, o_cout, o_zf, o_sf, o_pf, o_ov;
    logic [15:0] o_sum;

    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .sub(sub), .A(A), .B(B), .Cin(Cin),
        .busy(busy4), .done(done4), .Sum(sum4), .Cout(cout4),
        .Zf(zf4), .Sf(sf4), .Pf(pf4), .OVf(ov4)
    );

    seq_chunk_adder #(.WIDTH(16), .CHUNK(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .sub(sub), .A(A), .B(B), .Cin(Cin),
        .busy(busy1), .done(done1), .Sum(sum1), .Cout(cout1),
        .Zf(zf1), .Sf(sf1), .Pf(pf1), .OVf(ov1)
    );

    seq_chunk_adder #(.WIDTH(16), .CHUNK(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .sub(sub), .A(A), .B(B), .Cin(Cin),
        .busy(busy16), .done(done16), .Sum(sum16), .Cout(cout16),
        .Zf(zf16), .Sf(sf16), .Pf(pf16), .OVf(ov16)
    );

    // Route the selected instance's outputs to one set of observation signals.
    always_comb begin
        o_busy = busy4; o_done = done4; o_sum = sum4; o_cout = cout4;
        o_zf = zf4; o_sf = sf4; o_pf = pf4; o_ov = ov4;
        case (sel)
            1: begin
                o_busy = busy1; o_done = done1; o_sum = sum1; o_cout = cout1;
                o_zf = zf1; o_sf = sf1; o_pf = pf1; o_ov = ov1;
            end
            2: begin
                o_busy = busy16; o_done = done16; o_sum = sum16; o_cout = cout16;
                o_zf = zf16; o_sf = sf16; o_pf = pf16; o_ov = ov16;
            end
            default: ;
        endcase
    end

    function automatic int latency_of(input int which);
        case (which)
            1:       return 16;
            2:       return 1;
            default: return 4;
        endcase
    endfunction

    // Reference: whole-word arithmetic with signed range check for overflow.
    function automatic res_t model(input logic [15:0] a, input logic [15:0] b,
                                   input logic ci, input logic s);
        res_t        r;
        logic [15:0] beff;
        int unsigned c;
        int unsigned total;
        int          sres;
        int unsigned ones;
        beff   = s ? ~b : b;
        c      = s ? 1 : int'(ci);
        total  = int'(a) + int'(beff) + c;
        r.sum  = total[15:0];
        r.cout = (total >= 65536);
        r.zf   = (r.sum == 16'h0000);
        r.sf   = (r.sum >= 16'h8000);
        ones   = 0;
        for (int i = 0; i < 16; i++) ones += r.sum[i];
        r.pf   = ((ones % 2) == 0);
        sres   = int'($signed(a)) + int'($signed(beff)) + int'(c);
        r.ov   = (sres > 32767) || (sres < -32768);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_start(input int which, input logic v);
        case (which)
            1:       start1  = v;
            2:       start16 = v;
            default: start4  = v;
        endcase
    endtask

    task automatic check_result(input string tag, input res_t e);
        chk({tag, "_sum"},  32'(o_sum),  32'(e.sum));
        chk({tag, "_cout"}, 32'(o_cout), 32'(e.cout));
        chk({tag, "_zf"},   32'(o_zf),   32'(e.zf));
        chk({tag, "_sf"},   32'(o_sf),   32'(e.sf));
        chk({tag, "_pf"},   32'(o_pf),   32'(e.pf));
        chk({tag, "_ovf"},  32'(o_ov),   32'(e.ov));
    endtask

    // Launch one operation and follow it to its done pulse; returns at #1 after the done edge.
    task automatic run_op(input int which, input logic [15:0] a, input logic [15:0] b,
                          input logic ci, input logic s, input bit poke,
                          input string tag, output res_t e);
        int n;
        int busy_cnt;
        bit seen;
        e   = model(a, b, ci, s);
        sel = which;
        A = a; B = b; Cin = ci; sub = s;
        set_start(which, 1'b1);
        @(posedge clk); #1;
        set_start(which, 1'b0);
        A   = 16'($urandom);
        B   = 16'($urandom);
        Cin = 1'($urandom);
        sub = 1'($urandom);
        busy_cnt = o_busy ? 1 : 0;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            set_start(which, (poke && n == 1) ? 1'b1 : 1'b0);
            @(posedge clk); #1;
            n++;
            if (o_done) seen = 1'b1;
            else if (o_busy) busy_cnt++;
        end
        set_start(which, 1'b0);
        chk({tag, "_latency"}, 32'(n), 32'(latency_of(which)));
        chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(latency_of(which)));
        chk({tag, "_busy_at_done"}, 32'(o_busy), 32'd0);
        check_result(tag, e);
    endtask

    // One cycle after done with no start: pulse gone, results held.
    task automatic idle_check(input string tag, input res_t e);
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, 32'(o_done), 32'd0);
        chk({tag, "_idle_busy"}, 32'(o_busy), 32'd0);
        chk({tag, "_hold_sum"}, 32'(o_sum), 32'(e.sum));
        chk({tag, "_hold_cout"}, 32'(o_cout), 32'(e.cout));
    endtask

    initial begin
        res_t e;
        bit   saw_done;
        rst = 1'b1; start4 = 1'b0; start1 = 1'b0; start16 = 1'b0;
        A = 16'h0; B = 16'h0; Cin = 1'b0; sub = 1'b0; sel = 0;
        repeat (2) @(posedge clk);
        #1;
        for (int w = 0; w < 3; w++) begin
            sel = w;
            #1;
            chk("reset_busy", 32'(o_busy), 32'd0);
            chk("reset_done", 32'(o_done), 32'd0);
            chk("reset_sum", 32'(o_sum), 32'd0);
            chk("reset_flags", {27'd0, o_cout, o_zf, o_sf, o_pf, o_ov}, 32'd0);
        end
        rst = 1'b0;
        sel = 0;
        @(posedge clk); #1;

        // Directed cases on CHUNK=4.
        run_op(0, 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0, "t1", e);
        idle_check("t1", e);
        run_op(0, 16'h0001, 16'hAFCF, 1'b0, 1'b0, 1'b0, "t2a", e);
        run_op(0, 16'hF0FF, 16'h0011, 1'b0, 1'b0, 1'b0, "t2b", e);
        idle_check("t2b", e);
        run_op(0, 16'h8000, 16'h8200, 1'b0, 1'b0, 1'b0, "t3", e);
        idle_check("t3", e);
        run_op(0, 16'h1234, 16'h1234, 1'b0, 1'b1, 1'b0, "t5a", e);
        idle_check("t5a", e);
        run_op(0, 16'h0000, 16'h0001, 1'b0, 1'b1, 1'b0, "t5b", e);
        idle_check("t5b", e);
        run_op(0, 16'h4321, 16'h1111, 1'b0, 1'b0, 1'b1, "t6_poke", e);
        idle_check("t6_poke", e);
        run_op(0, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0, "t4", e);
        idle_check("t4", e);

        // Abort at chunk 2: Cout/Zf/Pf were 1 from the previous case.
        sel = 0;
        A = 16'h7777; B = 16'h1111; Cin = 1'b0; sub = 1'b0;
        start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_busy", 32'(o_busy), 32'd0);
        chk("abort_done", 32'(o_done), 32'd0);
        chk("abort_sum", 32'(o_sum), 32'd0);
        chk("abort_flags", {27'd0, o_cout, o_zf, o_sf, o_pf, o_ov}, 32'd0);
        saw_done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (o_done || o_busy) saw_done = 1'b1;
        end
        chk("abort_no_done", 32'(saw_done), 32'd0);

        // Parameter corners: case 3 on CHUNK=16 and CHUNK=1.
        run_op(2, 16'h8000, 16'h8200, 1'b0, 1'b0, 1'b0, "c16_t3", e);
        idle_check("c16_t3", e);
        run_op(1, 16'h8000, 16'h8200, 1'b0, 1'b0, 1'b0, "c1_t3", e);
        idle_check("c1_t3", e);
        run_op(1, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b1, "c1_ripple", e);
        idle_check("c1_ripple", e);

        // Randomized operations, sometimes chained back-to-back.
        for (int i = 0; i < 40; i++) begin
            run_op(0, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
                   1'($urandom), "rnd4", e);
            if ($urandom_range(0, 1) == 0) idle_check("rnd4", e);
        end
        for (int i = 0; i < 10; i++) begin
            run_op(1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
                   1'($urandom), "rnd1", e);
            run_op(2, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
                   1'b0, "rnd16", e);
            idle_check("rnd16", e);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
